fltr_evt_arb: RTL
=================

# fltr_evt_arb

Round-robin event arbiter that shares a single downstream event port between CH filter channels. Each channel's filter output is edge-detected into a sticky pending flag. The arbiter grants one pending channel at a time and presents its index on a valid/ready port, tracking events lost to overrun. It sits directly after the bank of filter instances and feeds the event consumer (CPU mailbox or logger).

## Interface
- CH, default 4: number of filter channels, 2..16.
- IDW, default 2: channel index width, equal to $clog2(CH).
- clk  in  1: single clock; all logic is on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- evt_in  in  CH: filter outputs, one per channel; level signals.
- ch_en  in  CH: per-channel enable mask.
- evt_valid  out  1: event offered downstream.
- evt_id  out  IDW: channel index of the offered event.
- evt_ready  in  1: downstream accept.
- ovf  out  CH: sticky per-channel overrun flags.
- ovf_clr  in  1: single-cycle pulse that clears all ovf bits.
- drop_cnt  out  8: saturating count of dropped events, all channels.

## Operation
- Input conditioning: per channel, in_q <= evt_in and in_qq <= in_q. edge[i] = in_q[i] & ~in_qq[i]. A level held high produces exactly one event.
- Pending register pend[CH]:
  - set on edge[i] & ch_en[i];
  - cleared on transfer of channel i;
  - cleared when ch_en[i]=0, unless i is the channel currently offered.
- Drop: edge[i] & ch_en[i] & pend[i], with no transfer of i in the same cycle. Effects: ovf[i] <= 1 and drop_cnt += 1, saturating at 255. When the edge coincides with the transfer of i, pend[i] stays 1 and nothing is counted as dropped.
- Disabled channels (ch_en=0) ignore edges; this is neither a pend set nor a drop.
- FSM states:
  - ARB_IDLE: evt_valid=0. If any pend bit is set, latch the grant and go to ARB_OFFER.
  - ARB_OFFER: evt_valid=1 and evt_id=grant. On evt_valid & evt_ready, clear pend[grant], set rr_ptr <= grant+1 (wrapping at CH to 0), and return to ARB_IDLE.
- Grant selection: the first set pend bit scanning upward from rr_ptr, wrapping. rr_ptr resets to 0.
- evt_id and evt_valid stay stable from assertion until the transfer. Disabling the granted channel mid-offer does not withdraw the offer.
- ovf_clr clears all ovf bits. A drop in the same cycle wins: that ovf bit is set. ovf_clr does not affect drop_cnt.
- Reset values: evt_valid=0, evt_id=0, ovf=0, drop_cnt=0, pend=0, in_q=in_qq=0, rr_ptr=0, state ARB_IDLE. Reset mid-offer drops the offer immediately, with no transfer.

## Timing
- Clock edges counted from the edge E0 at which evt_in[i] is first sampled high, with the FSM idle:
  - E1: pend[i]=1.
  - E2: FSM enters ARB_OFFER.
  - evt_valid is high after E2, a 2-cycle latency.
- Transfer occurs at the edge where evt_valid & evt_ready. evt_valid is low for the following cycle.
- Maximum throughput is one event per 2 cycles. evt_ready held high gives alternating valid cycles.
- evt_ready asserted with evt_valid low has no effect.
- evt_in is treated as synchronous to clk. The 2-flop stage is for edge detection, not CDC.

## Configuration
- FLTR_ARB_DROP_CNT_EN defined: drop_cnt counter implemented as described.
- Not defined: drop_cnt is tied to 8'h00 and the counter logic is removed. ovf flags and drop detection are unchanged.

## Test plan
- Single event: CH=4, ch_en=4'hF, evt_in[2] rises and is held high 10 cycles -> one evt_valid with evt_id=2 at 2-cycle latency, no further events.
- Round-robin: evt_in[0..3] all rise together, evt_ready=1 -> evt_id sequence 0,1,2,3 on alternating cycles. A second burst, after transfer of channel 1 and with 0 and 3 pending, grants 3 then 0.
- Backpressure: evt_ready=0 for 20 cycles while evt_in[1] pulses twice -> evt_valid/evt_id=1 stable throughout, ovf[1]=1, drop_cnt=1. With the macro undefined, drop_cnt=0.
- Coincident clear: a new edge on channel 3 in the transfer cycle of channel 3 -> no drop, and channel 3 is offered again after one idle cycle.
- Enable mask: ch_en[0]=0, then evt_in[0] rises -> no event, no drop. Deassert ch_en[2] while pend[2] is set but not granted -> pend[2] cleared, no event.
- Reset/clear: assert rst mid-offer -> evt_valid=0 and pend=0 asynchronously. ovf_clr coincident with a drop on channel 1 -> ovf[1] remains 1, other bits clear; drop_cnt saturates at 255 after 300 drops.

Source files
------------

// File: rtl/fltr_evt_arb.sv
// fltr_evt_arb: round-robin arbiter sharing one valid/ready event port across CH filter channels.
// Define FLTR_ARB_DROP_CNT_EN to implement the saturating drop_cnt counter (tied to zero otherwise).
module fltr_evt_arb #(
  parameter int CH  = 4,
  parameter int IDW = $clog2(CH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  evt_in,
  input  logic [CH-1:0]  ch_en,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [CH-1:0]  ovf,
  input  logic           ovf_clr,
  output logic [7:0]     drop_cnt
);
  typedef enum logic {ARB_IDLE, ARB_OFFER} state_t;
  state_t state;
  logic [CH-1:0] in_q, in_qq, pend, edg, set, xfer, hold, drop, elig;
  logic [IDW-1:0] rr_ptr, sel, idx;
  assign edg  = in_q & ~in_qq;
  assign set  = edg & ch_en;
  assign drop = set & pend & ~xfer;
  // A disabled channel is never granted; its pend bit is cleared on this same edge.
  assign elig = pend & ch_en;
  always_comb begin
    xfer = '0;
    hold = '0;
    for (int i = 0; i < CH; i++) begin
      hold[i] = state == ARB_OFFER && evt_id == IDW'(i);
      xfer[i] = hold[i] && evt_ready;
    end
  end
  // Scan downward from the farthest slot so the nearest eligible channel past rr_ptr wins.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % CH);
      sel = elig[idx] ? idx : sel;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q  <= '0;
      in_qq <= '0;
      pend  <= '0;
      ovf   <= '0;
    end else begin
      in_q  <= evt_in;
      in_qq <= in_q;
      pend  <= set | (pend & ~xfer & (ch_en | hold));
      ovf   <= (ovf & {CH{~ovf_clr}}) | drop;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else if (state == ARB_IDLE) begin
      if (|elig) begin
        state     <= ARB_OFFER;
        evt_valid <= 1'b1;
        evt_id    <= sel;
      end
    end else if (evt_ready) begin
      state     <= ARB_IDLE;
      evt_valid <= 1'b0;
      rr_ptr    <= evt_id == IDW'(CH - 1) ? '0 : evt_id + 1'b1;
    end
  end
`ifdef FLTR_ARB_DROP_CNT_EN
  logic [8:0] cnt_sum;
  always_comb begin
    cnt_sum = {1'b0, drop_cnt};
    for (int i = 0; i < CH; i++)
      cnt_sum = cnt_sum + {8'd0, drop[i]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= 8'h00;
    else drop_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end
`else
  assign drop_cnt = 8'h00;
`endif
endmodule
